// File: rtl/fifo_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared state encoding and width helper for fifo_write_arbiter.
// Revision    : 1.0
// ============================================================================
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // ceil(log2(n)), never narrower than one bit
    function automatic int clog2w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_arbiter_if
// Description : Producer request bus plus FIFO write-port signals.
// Revision    : 1.0
// ============================================================================
interface fifo_write_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int OWNER_W    = fifo_arb_pkg::clog2w(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_full;
    logic                          fifo_wen;
    logic [DATA_WIDTH-1:0]         fifo_din;
    logic [OWNER_W-1:0]            owner;
    logic                          busy;

    modport master (
        input  req, req_last, req_data, fifo_full,
        output gnt, fifo_wen, fifo_din, owner, busy
    );

    modport slave (
        output req, req_last, req_data, fifo_full,
        input  gnt, fifo_wen, fifo_din, owner, busy
    );
endinterface
`default_nettype wire

// File: rtl/fifo_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker: first set req at or after ptr.
// Revision    : 1.0
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);
    localparam int c_W2 = 2 * NUM_REQ;

    logic [NUM_REQ-1:0] w_mask;
    logic [c_W2-1:0]    w_dbl;
    logic [c_W2-1:0]    w_first;
    logic [c_W2:0]      w_seen;
    logic [IDX_W-1:0]   w_acc [c_W2+1];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_mask
        assign w_mask[i] = (IDX_W'(i) >= ptr);
    end

    // Lower half holds requests at/after ptr, upper half the wrapped set,
    // so the lowest set bit of the doubled vector is the round-robin winner.
    assign w_dbl     = {req, req & w_mask};
    assign w_seen[0] = 1'b0;
    assign w_acc[0]  = '0;

    for (genvar i = 0; i < c_W2; i++) begin : g_scan
        assign w_first[i]  = w_dbl[i] & ~w_seen[i];
        assign w_seen[i+1] = w_seen[i] | w_dbl[i];
        assign w_acc[i+1]  = w_acc[i] | ({IDX_W{w_first[i]}} & IDX_W'(i % NUM_REQ));
    end

    assign found = w_seen[c_W2];
    assign idx   = w_acc[c_W2];
endmodule
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_arbiter
// Description : Burst-based round-robin arbiter for a single FIFO write port.
// Revision    : 1.0
// ============================================================================
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    fifo_write_arbiter_if.master bus
);
    localparam int OWNER_W = clog2w(NUM_REQ);
    localparam int CNT_W   = clog2w(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]   c_MAX_BURST = CNT_W'(MAX_BURST);
    localparam logic [OWNER_W-1:0] c_LAST_IDX  = OWNER_W'(NUM_REQ - 1);

    state_t             r_state, w_state_nxt;
    logic [OWNER_W-1:0] r_owner, w_owner_nxt;
    logic [OWNER_W-1:0] r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;
    logic [OWNER_W-1:0] w_owner_inc;
    logic [CNT_W-1:0]   w_beat_cnt_inc;
    logic [OWNER_W-1:0] w_pick_idx;
    logic               w_pick_found;
    logic               w_xfer;
    logic [NUM_REQ-1:0] w_gnt;
    logic [DATA_WIDTH-1:0] w_din;
    logic [DATA_WIDTH-1:0] w_req_data [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_req_data[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OWNER_W)
    ) u_rr_pick (
        .req   (bus.req),
        .ptr   (r_ptr),
        .found (w_pick_found),
        .idx   (w_pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_ptr      <= w_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    always_comb begin
        w_owner_inc    = (r_owner == c_LAST_IDX) ? '0 : r_owner + 1'b1;
        w_beat_cnt_inc = r_beat_cnt + 1'b1;
        // Full gating is per cycle, so a stalled beat is simply retried
        w_xfer = (r_state == ST_BURST) && bus.req[r_owner] && !bus.fifo_full && !clear;

        w_gnt = '0;
        if (w_xfer) begin
            w_gnt[r_owner] = 1'b1;
        end
        w_din = w_xfer ? w_req_data[r_owner] : '0;

        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_ptr_nxt      = r_ptr;
        w_beat_cnt_nxt = r_beat_cnt;

        if (clear) begin
            w_state_nxt    = ST_IDLE;
            w_owner_nxt    = '0;
            w_ptr_nxt      = '0;
            w_beat_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_found) begin
                        w_state_nxt    = ST_BURST;
                        w_owner_nxt    = w_pick_idx;
                        w_beat_cnt_nxt = '0;
                    end
                end
                ST_BURST: begin
                    if (!bus.req[r_owner]) begin
                        w_state_nxt = ST_IDLE;
                        w_ptr_nxt   = w_owner_inc;
                    end else if (w_xfer) begin
                        w_beat_cnt_nxt = w_beat_cnt_inc;
                        if (bus.req_last[r_owner] || (w_beat_cnt_inc == c_MAX_BURST)) begin
                            w_state_nxt = ST_IDLE;
                            w_ptr_nxt   = w_owner_inc;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt      = w_gnt;
    assign bus.fifo_wen = w_xfer;
    assign bus.fifo_din = w_din;
    assign bus.owner    = r_owner;
    assign bus.busy     = (r_state == ST_BURST);
endmodule
`default_nettype wire
